// File: rtl/fwd_ctrl_if.sv
// fwd_ctrl_if: bundle between ID/EX pipeline control and the forwarding/hazard
// controller.
//   ID side (into controller): id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i,
//     id_rs2_used_i, id_rd_i, id_reg_write_i, id_mem_read_i, flush_i, hold_i
//   Controller side (out):      stall_o, ex_valid_o, fwd_a_sel_o, fwd_b_sel_o
// master = pipeline control driving ID fields; slave = fwd_ctrl.
interface fwd_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
  logic                      id_rs1_used_i;
  logic                      id_rs2_used_i;
  logic [REG_ADDR_WIDTH-1:0] id_rd_i;
  logic                      id_reg_write_i;
  logic                      id_mem_read_i;
  logic                      flush_i;
  logic                      hold_i;
  logic                      stall_o;
  logic                      ex_valid_o;
  logic [1:0]                fwd_a_sel_o;
  logic [1:0]                fwd_b_sel_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_reg_write_i, id_mem_read_i, flush_i, hold_i,
    input  stall_o, ex_valid_o, fwd_a_sel_o, fwd_b_sel_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_reg_write_i, id_mem_read_i, flush_i, hold_i,
    output stall_o, ex_valid_o, fwd_a_sel_o, fwd_b_sel_o
  );
endinterface

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding select and load-use hazard controller.
// Tracks destination tags through EX (p0), MEM (p1), WB (p2) and RET (p3).
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, clears all stage valid bits
//   bus      : fwd_ctrl_if.slave (ID record in; stall, EX valid, selects out)
// Select codes: 0=register file, 1=MEM, 2=WB, 3=RET (only when RET_FWD=1).
module fwd_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit RET_FWD        = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fwd_ctrl_if.slave    bus
);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

  logic vld_p0, vld_p1, vld_p2, vld_p3;
  reg_t rs1_p0, rs2_p0;
  logic rs1_used_p0, rs2_used_p0, mem_read_p0;
  reg_t rd_p0, rd_p1, rd_p2, rd_p3;
  logic we_p0, we_p1, we_p2, we_p3;

  logic stall;
  logic load_p0;
  logic a_ok, a_mem, a_wb, a_ret;
  logic b_ok, b_mem, b_wb, b_ret;

  // x0 is never a producer, so a zero tag can never hit.
  function automatic logic tag_hit(logic vld, logic we, reg_t rd, reg_t rs);
    return vld & we & (rd != '0) & (rd == rs);
  endfunction

  // Youngest producer wins: MEM before WB before RET.
  function automatic logic [1:0] pick_sel(logic ok, logic hit_mem,
                                          logic hit_wb, logic hit_ret);
    logic [1:0] sel;
    sel = 2'd0;
    if (ok) begin
      if (hit_mem)                sel = 2'd1;
      else if (hit_wb)            sel = 2'd2;
      else if (RET_FWD && hit_ret) sel = 2'd3;
    end
    return sel;
  endfunction

  // EX stage: forwarding selects and load-use detection
  always_comb begin
    a_ok  = vld_p0 & rs1_used_p0 & (rs1_p0 != '0);
    a_mem = tag_hit(vld_p1, we_p1, rd_p1, rs1_p0);
    a_wb  = tag_hit(vld_p2, we_p2, rd_p2, rs1_p0);
    a_ret = tag_hit(vld_p3, we_p3, rd_p3, rs1_p0);
    b_ok  = vld_p0 & rs2_used_p0 & (rs2_p0 != '0);
    b_mem = tag_hit(vld_p1, we_p1, rd_p1, rs2_p0);
    b_wb  = tag_hit(vld_p2, we_p2, rd_p2, rs2_p0);
    b_ret = tag_hit(vld_p3, we_p3, rd_p3, rs2_p0);
    load_p0 = vld_p0 & mem_read_p0 & we_p0 & (rd_p0 != '0);
    // Flush kills the ID instruction, so it can never request a stall.
    stall = load_p0 & bus.id_valid_i & ~bus.flush_i &
            ((bus.id_rs1_used_i & (bus.id_rs1_i == rd_p0)) |
             (bus.id_rs2_used_i & (bus.id_rs2_i == rd_p0)));
  end

  assign bus.stall_o     = stall;
  assign bus.ex_valid_o  = vld_p0;
  assign bus.fwd_a_sel_o = pick_sel(a_ok, a_mem, a_wb, a_ret);
  assign bus.fwd_b_sel_o = pick_sel(b_ok, b_mem, b_wb, b_ret);

  // Stage advance: valid bits (control)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (!bus.hold_i) begin
      vld_p0 <= bus.id_valid_i & ~stall & ~bus.flush_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Stage advance: tag fields (qualified by the valid bits above)
  always_ff @(posedge clk_i) begin
    if (!bus.hold_i) begin
      rs1_p0      <= bus.id_rs1_i;
      rs2_p0      <= bus.id_rs2_i;
      rs1_used_p0 <= bus.id_rs1_used_i;
      rs2_used_p0 <= bus.id_rs2_used_i;
      rd_p0       <= bus.id_rd_i;
      we_p0       <= bus.id_reg_write_i;
      mem_read_p0 <= bus.id_mem_read_i;
      rd_p1       <= rd_p0;
      we_p1       <= we_p0;
      rd_p2       <= rd_p1;
      we_p2       <= we_p1;
      rd_p3       <= rd_p2;
      we_p3       <= we_p2;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: two instances (RET_FWD=1 and RET_FWD=0) share the same
// stimulus; a stage-list model predicts stall/valid/selects every cycle.
module tb_fwd_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_mr, flush, hold;
  logic [4:0] id_rs1, id_rs2, id_rd;

  fwd_ctrl_if #(.REG_ADDR_WIDTH(5)) ifa ();
  fwd_ctrl_if #(.REG_ADDR_WIDTH(5)) ifb ();

  assign ifa.id_valid_i = id_valid;  assign ifb.id_valid_i = id_valid;
  assign ifa.id_rs1_i = id_rs1;      assign ifb.id_rs1_i = id_rs1;
  assign ifa.id_rs2_i = id_rs2;      assign ifb.id_rs2_i = id_rs2;
  assign ifa.id_rs1_used_i = id_rs1_used; assign ifb.id_rs1_used_i = id_rs1_used;
  assign ifa.id_rs2_used_i = id_rs2_used; assign ifb.id_rs2_used_i = id_rs2_used;
  assign ifa.id_rd_i = id_rd;        assign ifb.id_rd_i = id_rd;
  assign ifa.id_reg_write_i = id_we; assign ifb.id_reg_write_i = id_we;
  assign ifa.id_mem_read_i = id_mr;  assign ifb.id_mem_read_i = id_mr;
  assign ifa.flush_i = flush;        assign ifb.flush_i = flush;
  assign ifa.hold_i = hold;          assign ifb.hold_i = hold;

  fwd_ctrl #(.REG_ADDR_WIDTH(5), .RET_FWD(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  fwd_ctrl #(.REG_ADDR_WIDTH(5), .RET_FWD(1'b0)) dut_noret (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave));

  // ---------------- model: list of in-flight instructions ----------------
  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, mr;
  } rec_t;
  rec_t st [4];  // 0=EX 1=MEM 2=WB 3=RET

  function automatic logic m_stall();
    if (!(st[0].vld && st[0].mr && st[0].we && st[0].rd != 0)) return 1'b0;
    if (!(id_valid && !flush)) return 1'b0;
    return (id_rs1_used && id_rs1 == st[0].rd) || (id_rs2_used && id_rs2 == st[0].rd);
  endfunction

  // Search older stages youngest-first for a writer of rs.
  function automatic logic [3:0] m_sel(logic used, logic [4:0] rs, logic ret_en);
    if (!st[0].vld || !used || rs == 0) return 4'd0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3 && !ret_en) return 4'd0;
      if (st[k].vld && st[k].we && st[k].rd == rs) return 4'(k);
    end
    return 4'd0;
  endfunction

  initial for (int k = 0; k < 4; k++) st[k].vld = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) st[k].vld <= 1'b0;
    end else if (!hold) begin
      st[3] <= st[2];
      st[2] <= st[1];
      st[1] <= st[0];
      st[0] <= '{vld: id_valid && !flush && !m_stall(), rs1: id_rs1, rs2: id_rs2,
                 rd: id_rd, u1: id_rs1_used, u2: id_rs2_used, we: id_we, mr: id_mr};
    end
  end

  // ---------------- checking ----------------
  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",       {3'b0, ifa.stall_o},    {3'b0, m_stall()});
      chk("ex_valid",    {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld});
      chk("sel_a",       {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1));
      chk("sel_b",       {2'b0, ifa.fwd_b_sel_o}, m_sel(st[0].u2, st[0].rs2, 1'b1));
      chk("noret_stall", {3'b0, ifb.stall_o},    {3'b0, m_stall()});
      chk("noret_valid", {3'b0, ifb.ex_valid_o}, {3'b0, st[0].vld});
      chk("noret_sel_a", {2'b0, ifb.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b0));
      chk("noret_sel_b", {2'b0, ifb.fwd_b_sel_o}, m_sel(st[0].u2, st[0].rs2, 1'b0));
    end
  end

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [3:0] dut_v,
                     input logic [3:0] mdl_v, input logic [3:0] exp);
    chk(name, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  task automatic at();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic we, input logic mr, input logic fl,
                      input logic hd, input logic r);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_mr = mr; flush = fl; hold = hd; rst = r;
  endtask

  task automatic op(input logic [4:0] rd, input logic we, input logic mr,
                    input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2);
    step(1'b1, rs1, u1, rs2, u2, rd, we, mr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold_nop();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    repeat (4) nop();
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
    id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom); id_rd = 5'($urandom);
    id_we = 1'($urandom); id_mr = 1'($urandom); flush = 1'($urandom);
    hold = 1'b0;
  endtask

  initial begin
    // Reset for two edges with random ID inputs
    rst = 1'b1;
    rand_id();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    rand_id();
    at();
    lit("rst_valid", {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld}, 4'd0);
    lit("rst_stall", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd0);
    lit("rst_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd0);
    nop();
    at();
    lit("post_rst_valid", {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld}, 4'd0);
    lit("post_rst_sel_b", {2'b0, ifa.fwd_b_sel_o}, m_sel(st[0].u2, st[0].rs2, 1'b1), 4'd0);

    // Back-to-back ALU dependency
    op(5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
    op(5'd12, 1, 0, 5'd5, 1, 5'd5, 1);
    nop();
    at();
    lit("b2b_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd1);
    lit("b2b_sel_b", {2'b0, ifa.fwd_b_sel_o}, m_sel(st[0].u2, st[0].rs2, 1'b1), 4'd1);
    drain();

    // Distance 2
    op(5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd10, 1, 0, 5'd1, 1, 5'd0, 0);
    op(5'd13, 1, 0, 5'd7, 1, 5'd0, 0);
    nop();
    at();
    lit("dist2_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd2);
    drain();

    // Distance 3, with and without RET forwarding
    op(5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd10, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd11, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd13, 1, 0, 5'd7, 1, 5'd0, 0);
    nop();
    at();
    lit("dist3_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd3);
    lit("dist3_noret", {2'b0, ifb.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b0), 4'd0);
    drain();

    // Two producers of r7: youngest wins
    op(5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd7, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd13, 1, 0, 5'd7, 1, 5'd0, 0);
    nop();
    at();
    lit("youngest_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd1);
    drain();

    // Load-use on rs2
    op(5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
    op(5'd14, 1, 0, 5'd0, 0, 5'd9, 1);
    at();
    lit("lu_stall", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd1);
    op(5'd14, 1, 0, 5'd0, 0, 5'd9, 1);
    at();
    lit("lu_stall_once", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd0);
    lit("lu_bubble", {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld}, 4'd0);
    nop();
    at();
    lit("lu_sel_b", {2'b0, ifa.fwd_b_sel_o}, m_sel(st[0].u2, st[0].rs2, 1'b1), 4'd2);
    drain();

    // x0 producer (a load) and x0 consumer
    op(5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
    op(5'd15, 1, 0, 5'd0, 1, 5'd0, 1);
    at();
    lit("x0_stall", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd0);
    nop();
    at();
    lit("x0_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd0);
    drain();

    // Load rd=3, consumer names r3 in rs1 but does not read it
    op(5'd3, 1, 1, 5'd0, 0, 5'd0, 0);
    op(5'd16, 1, 0, 5'd3, 0, 5'd4, 1);
    at();
    lit("unused_stall", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd0);
    drain();

    // Flush beats stall
    op(5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
    step(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    at();
    lit("flush_stall", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd0);
    nop();
    at();
    lit("flush_bubble", {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld}, 4'd0);
    drain();

    // Hold during forwarding, then tags resume
    op(5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
    op(5'd17, 0, 0, 5'd5, 1, 5'd0, 0);
    repeat (3) begin
      hold_nop();
      at();
      lit("hold_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd1);
    end
    op(5'd18, 1, 0, 5'd5, 1, 5'd0, 0);
    at();
    lit("release_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd1);
    nop();
    at();
    lit("resume_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd2);
    drain();

    // Hold while a stall is pending
    op(5'd9, 1, 1, 5'd0, 0, 5'd0, 0);
    repeat (2) begin
      step(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      at();
      lit("hold_stall", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd1);
    end
    op(5'd14, 1, 0, 5'd0, 0, 5'd9, 1);
    at();
    lit("hold_stall_rel", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd1);
    op(5'd14, 1, 0, 5'd0, 0, 5'd9, 1);
    at();
    lit("hold_stall_done", {3'b0, ifa.stall_o}, {3'b0, m_stall()}, 4'd0);
    nop();
    at();
    lit("hold_lu_sel_b", {2'b0, ifa.fwd_b_sel_o}, m_sel(st[0].u2, st[0].rs2, 1'b1), 4'd2);
    drain();

    // Reset mid-operation discards in-flight tags
    op(5'd5, 1, 0, 5'd0, 0, 5'd0, 0);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    at();
    lit("pre_rst_valid", {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld}, 4'd1);
    nop();
    at();
    lit("mid_rst_valid", {3'b0, ifa.ex_valid_o}, {3'b0, st[0].vld}, 4'd0);
    lit("mid_rst_sel_a", {2'b0, ifa.fwd_a_sel_o}, m_sel(st[0].u1, st[0].rs1, 1'b1), 4'd0);
    drain();

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
